l1d_req_arb: RTL and testbench

- Arbitrates REQ_NUM upstream requesters (load pipe, store-buffer drain, prefetcher) onto the single tag-pipe request port of l1d_data_top.
- Owns the cancel/replay protocol: a transfer cancelled by cancel_last_trans is re-issued ahead of new requests.
- Round-robin among requesters, one registered output stage, 2-entry replay queue.

---
 rtl/l1d_req_arb_pkg.sv | 24 ++
 rtl/l1d_req_arb_rr.sv | 43 ++++
 rtl/l1d_req_arb.sv | 141 ++++++++++++++
 tb/tb_l1d_req_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1d_req_arb_pkg.sv
// Shared types for the L1D tag-pipe request arbiter.
// Holds the tag request payload and the replay-queue entry layout.
package l1d_req_arb_pkg;

  localparam int L1D_REQ_ARB_NUM = 3;
  localparam int REQ_ID_W = $clog2(L1D_REQ_ARB_NUM);
  localparam int L1D_ADDR_W = 32;

  typedef struct packed {
    logic [L1D_ADDR_W-1:0] addr;
    logic [1:0]            op;
  } pack_l1d_tag_req;

  typedef struct packed {
    pack_l1d_tag_req     pld;
    logic [REQ_ID_W-1:0] src;
  } pack_l1d_req_arb_replay;

  typedef enum logic {
    OR_EMPTY,
    OR_FULL
  } or_st_t;

endpackage

// File: rtl/l1d_req_arb_rr.sv
// Round-robin pick: first valid index at or after the pointer.
// Pointer moves past the winner only when the grant is taken.
module l1d_req_arb_rr #(
  parameter int REQ_NUM = 3,
  parameter int ID_W = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] vld,
  input  logic               adv,
  output logic [REQ_NUM-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] ptr;
  int              j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      j = int'(ptr) + k;
      if (j >= REQ_NUM) j = j - REQ_NUM;
      if (!any && vld[j]) begin
        any    = 1'b1;
        idx    = ID_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (idx == ID_W'(REQ_NUM - 1)) ? '0 : idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/l1d_req_arb.sv
// L1D tag-pipe request arbiter with cancel/replay and one output register.
// Optional perf counters under L1D_REQ_ARB_PERF_EN.
module l1d_req_arb
  import l1d_req_arb_pkg::*;
#(
  parameter int REQ_NUM = L1D_REQ_ARB_NUM,
  parameter int REPLAY_DEPTH = 2
`ifdef L1D_REQ_ARB_PERF_EN
  ,
  parameter int PERF_CNT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQ_NUM-1:0]  req_vld,
  output logic [REQ_NUM-1:0]  req_rdy,
  input  pack_l1d_tag_req     req_pld [REQ_NUM],
  output logic                tag_req_vld,
  input  logic                tag_req_rdy,
  output pack_l1d_tag_req     tag_req_pld,
  output logic [REQ_ID_W-1:0] tag_req_src,
  input  logic                cancel_last_trans,
  output logic                replay_busy
`ifdef L1D_REQ_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] cancel_cnt,
  output logic [PERF_CNT_W-1:0] replay_cnt
`endif
);

  or_st_t                 or_st;
  or_st_t                 or_nxt;
  logic                   or_rep;
  logic                   la_vld;
  pack_l1d_req_arb_replay la;
  pack_l1d_req_arb_replay q [REPLAY_DEPTH];
  logic                   head;
  logic [1:0]             cnt;

  logic [REQ_NUM-1:0]  rr_gnt;
  logic [REQ_ID_W-1:0] rr_idx;
  logic                rr_any;

  logic or_load;
  logic hs;
  logic q_empty;
  logic q_full;
  logic pop;
  logic grant_any;
  logic push_req;
  logic push;
  logic wr_idx;

  assign tag_req_vld = (or_st == OR_FULL);
  assign replay_busy = !q_empty;

  assign q_empty   = (cnt == 2'd0);
  assign q_full    = (cnt == 2'(REPLAY_DEPTH));
  assign or_load   = (or_st == OR_EMPTY) || tag_req_rdy;
  assign hs        = tag_req_vld && tag_req_rdy;
  assign pop       = !q_empty && or_load;
  assign grant_any = rst_n && q_empty && or_load && rr_any;
  assign req_rdy   = grant_any ? rr_gnt : '0;

  // Replay tail sits at head+cnt; with a pop at full it reuses the head slot.
  assign push_req = cancel_last_trans && la_vld;
  assign push     = push_req && (!q_full || pop);
  assign wr_idx   = head ^ cnt[0];

  l1d_req_arb_rr #(
    .REQ_NUM (REQ_NUM),
    .ID_W    (REQ_ID_W)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (req_vld),
    .adv   (grant_any),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  always_comb begin
    or_nxt = or_st;
    if (pop || grant_any) or_nxt = OR_FULL;
    else if (hs)          or_nxt = OR_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_st       <= OR_EMPTY;
      tag_req_pld <= '0;
      tag_req_src <= '0;
      or_rep      <= 1'b0;
      la_vld      <= 1'b0;
      la          <= '0;
      head        <= 1'b0;
      cnt         <= 2'd0;
      for (int i = 0; i < REPLAY_DEPTH; i++) q[i] <= '0;
    end else begin
      or_st <= or_nxt;
      if (pop) begin
        tag_req_pld <= q[head].pld;
        tag_req_src <= q[head].src;
        or_rep      <= 1'b1;
      end else if (grant_any) begin
        tag_req_pld <= req_pld[rr_idx];
        tag_req_src <= rr_idx;
        or_rep      <= 1'b0;
      end
      la_vld <= hs;
      if (hs) begin
        la.pld <= tag_req_pld;
        la.src <= tag_req_src;
      end
      if (push) q[wr_idx] <= la;
      if (pop) head <= ~head;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  a_replay_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push_req && q_full && !pop)
  );

`ifdef L1D_REQ_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cancel_cnt <= '0;
      replay_cnt <= '0;
    end else begin
      if (push_req && cancel_cnt != '1)
        cancel_cnt <= cancel_cnt + PERF_CNT_W'(1);
      if (hs && or_rep && replay_cnt != '1)
        replay_cnt <= replay_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_l1d_req_arb.sv
// Directed bench for l1d_req_arb with a transfer scoreboard.
// Expected tag-port transfers are queued up front; a monitor pops them.
module tb_l1d_req_arb;
  import l1d_req_arb_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          req_vld;
  logic [2:0]          req_rdy;
  pack_l1d_tag_req     req_pld [3];
  logic                tag_req_vld;
  logic                tag_req_rdy;
  pack_l1d_tag_req     tag_req_pld;
  logic [REQ_ID_W-1:0] tag_req_src;
  logic                cancel_last_trans;
  logic                replay_busy;
`ifdef L1D_REQ_ARB_PERF_EN
  logic [15:0]         cancel_cnt;
  logic [15:0]         replay_cnt;
`endif

  int total = 0;
  int bad = 0;
  pack_l1d_req_arb_replay sb [$];

  always #5 clk = ~clk;

  l1d_req_arb dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_vld           (req_vld),
    .req_rdy           (req_rdy),
    .req_pld           (req_pld),
    .tag_req_vld       (tag_req_vld),
    .tag_req_rdy       (tag_req_rdy),
    .tag_req_pld       (tag_req_pld),
    .tag_req_src       (tag_req_src),
    .cancel_last_trans (cancel_last_trans),
    .replay_busy       (replay_busy)
`ifdef L1D_REQ_ARB_PERF_EN
    ,
    .cancel_cnt        (cancel_cnt),
    .replay_cnt        (replay_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic exp(input logic [31:0] a, input int s);
    pack_l1d_req_arb_replay e;
    e.pld.addr = a;
    e.pld.op   = 2'(s);
    e.src      = REQ_ID_W'(s);
    sb.push_back(e);
  endtask

  task automatic setp(input int i, input logic [31:0] a);
    req_pld[i].addr = a;
    req_pld[i].op   = 2'(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    pack_l1d_req_arb_replay e;
    if (rst_n && tag_req_vld && tag_req_rdy) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("xfer_pld", 64'(tag_req_pld), 64'(e.pld));
        chk("xfer_src", 64'(tag_req_src), 64'(e.src));
      end
    end
  end

  initial begin
    req_vld = 3'b111;
    tag_req_rdy = 1'b0;
    cancel_last_trans = 1'b0;
    for (int i = 0; i < 3; i++) setp(i, 32'h0);

    // reset state, requests asserted but must not be granted
    #12;
    chk("rst_vld", 64'(tag_req_vld), 0);
    chk("rst_rdy", 64'(req_rdy), 0);
    chk("rst_busy", 64'(replay_busy), 0);
    chk("rst_src", 64'(tag_req_src), 0);
    chk("rst_pld", 64'(tag_req_pld), 0);
    cyc();
    rst_n = 1'b1;
    req_vld = 3'b000;
    cyc();

    // round robin
    setp(0, 32'h1000);
    setp(1, 32'h1010);
    setp(2, 32'h1020);
    for (int k = 0; k < 6; k++) exp(32'h1000 + 32'(16 * (k % 3)), k % 3);
    req_vld = 3'b111;
    tag_req_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk($sformatf("rr_rdy%0d", k), 64'(req_rdy), 64'(3'b001 << (k % 3)));
      if (k > 0) chk($sformatf("rr_src%0d", k), 64'(tag_req_src),
                     64'((k - 1) % 3));
      cyc();
    end
    req_vld = 3'b000;
    mid();
    chk("rr_src_last", 64'(tag_req_src), 2);
    cyc();
    mid();
    chk("rr_idle_vld", 64'(tag_req_vld), 0);
    cyc();

    // backpressure
    exp(32'h100, 0);
    exp(32'h104, 0);
    setp(0, 32'h100);
    req_vld = 3'b001;
    tag_req_rdy = 1'b0;
    mid();
    chk("bp_grant", 64'(req_rdy), 64'(3'b001));
    cyc();
    setp(0, 32'h104);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk($sformatf("bp_vld%0d", k), 64'(tag_req_vld), 1);
      chk($sformatf("bp_addr%0d", k), 64'(tag_req_pld.addr), 64'h100);
      chk($sformatf("bp_rdy%0d", k), 64'(req_rdy), 0);
      cyc();
    end
    tag_req_rdy = 1'b1;
    mid();
    chk("bp_regrant", 64'(req_rdy), 64'(3'b001));
    cyc();
    req_vld = 3'b000;
    mid();
    chk("bp_addr2", 64'(tag_req_pld.addr), 64'h104);
    cyc();
    mid();
    cyc();

    // single cancel
    exp(32'h240, 1);
    exp(32'h300, 0);
    exp(32'h304, 0);
    exp(32'h240, 1);
    exp(32'h308, 0);
    setp(1, 32'h240);
    req_vld = 3'b010;
    mid();
    chk("sc_g1", 64'(req_rdy), 64'(3'b010));
    cyc();
    setp(0, 32'h300);
    req_vld = 3'b001;
    mid();
    chk("sc_g0", 64'(req_rdy), 64'(3'b001));
    cyc();
    setp(0, 32'h304);
    cancel_last_trans = 1'b1;
    mid();
    chk("sc_busy_t1", 64'(replay_busy), 0);
    chk("sc_g0b", 64'(req_rdy), 64'(3'b001));
    cyc();
    setp(0, 32'h308);
    cancel_last_trans = 1'b0;
    mid();
    chk("sc_busy_t2", 64'(replay_busy), 1);
    chk("sc_blocked", 64'(req_rdy), 0);
    chk("sc_or_addr", 64'(tag_req_pld.addr), 64'h304);
    cyc();
    mid();
    chk("sc_busy_t3", 64'(replay_busy), 0);
    chk("sc_rep_addr", 64'(tag_req_pld.addr), 64'h240);
    chk("sc_rep_src", 64'(tag_req_src), 1);
    chk("sc_resume", 64'(req_rdy), 64'(3'b001));
    cyc();
    req_vld = 3'b000;
    mid();
    cyc();
    mid();
    cyc();

    // stray cancel
    cancel_last_trans = 1'b1;
    mid();
    chk("st_vld", 64'(tag_req_vld), 0);
    cyc();
    cancel_last_trans = 1'b0;
    mid();
    chk("st_busy", 64'(replay_busy), 0);
`ifdef L1D_REQ_ARB_PERF_EN
    chk("st_cancel_cnt", 64'(cancel_cnt), 1);
    chk("st_replay_cnt", 64'(replay_cnt), 1);
`endif
    cyc();

    // back-to-back cancels
    exp(32'h500, 1);
    exp(32'h400, 0);
    exp(32'h600, 2);
    exp(32'h500, 1);
    exp(32'h400, 0);
    exp(32'h404, 0);
    setp(1, 32'h500);
    setp(0, 32'h400);
    req_vld = 3'b011;
    mid();
    chk("bb_gA", 64'(req_rdy), 64'(3'b010));
    cyc();
    req_vld = 3'b001;
    mid();
    chk("bb_gB", 64'(req_rdy), 64'(3'b001));
    cyc();
    setp(2, 32'h600);
    req_vld = 3'b100;
    cancel_last_trans = 1'b1;
    mid();
    chk("bb_gC", 64'(req_rdy), 64'(3'b100));
    cyc();
    setp(0, 32'h404);
    req_vld = 3'b001;
    tag_req_rdy = 1'b0;
    mid();
    chk("bb_busy1", 64'(replay_busy), 1);
    chk("bb_blk1", 64'(req_rdy), 0);
    cyc();
    cancel_last_trans = 1'b0;
    tag_req_rdy = 1'b1;
    mid();
    chk("bb_busy2", 64'(replay_busy), 1);
    chk("bb_blk2", 64'(req_rdy), 0);
    chk("bb_orC", 64'(tag_req_pld.addr), 64'h600);
    cyc();
    mid();
    chk("bb_busy3", 64'(replay_busy), 1);
    chk("bb_orA", 64'(tag_req_pld.addr), 64'h500);
    chk("bb_blk3", 64'(req_rdy), 0);
    cyc();
    mid();
    chk("bb_busy4", 64'(replay_busy), 0);
    chk("bb_orB", 64'(tag_req_pld.addr), 64'h400);
    chk("bb_resume", 64'(req_rdy), 64'(3'b001));
    cyc();
    req_vld = 3'b000;
    mid();
    chk("bb_or404", 64'(tag_req_pld.addr), 64'h404);
    cyc();
    mid();
    cyc();

    // reset with two queued replays
    exp(32'h800, 1);
    exp(32'h900, 0);
    setp(1, 32'h800);
    req_vld = 3'b010;
    mid();
    chk("rs_g1", 64'(req_rdy), 64'(3'b010));
    cyc();
    setp(0, 32'h900);
    req_vld = 3'b001;
    mid();
    chk("rs_g0", 64'(req_rdy), 64'(3'b001));
    cyc();
    setp(2, 32'hA00);
    req_vld = 3'b100;
    cancel_last_trans = 1'b1;
    mid();
    chk("rs_g2", 64'(req_rdy), 64'(3'b100));
    cyc();
    req_vld = 3'b000;
    tag_req_rdy = 1'b0;
    cancel_last_trans = 1'b1;
    cyc();
    cancel_last_trans = 1'b0;
    req_vld = 3'b111;
    mid();
    chk("rs_busy_pre", 64'(replay_busy), 1);
`ifdef L1D_REQ_ARB_PERF_EN
    chk("rs_cancel_cnt", 64'(cancel_cnt), 5);
    chk("rs_replay_cnt", 64'(replay_cnt), 3);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_vld", 64'(tag_req_vld), 0);
    chk("rs_busy", 64'(replay_busy), 0);
    chk("rs_rdy", 64'(req_rdy), 0);
    chk("rs_src", 64'(tag_req_src), 0);
    chk("rs_pld", 64'(tag_req_pld), 0);
`ifdef L1D_REQ_ARB_PERF_EN
    chk("rs_cancel_zero", 64'(cancel_cnt), 0);
    chk("rs_replay_zero", 64'(replay_cnt), 0);
`endif
    cyc();
    rst_n = 1'b1;
    req_vld = 3'b000;
    tag_req_rdy = 1'b1;
    cyc();
    exp(32'h700, 2);
    setp(2, 32'h700);
    req_vld = 3'b100;
    mid();
    chk("rs_fresh_g", 64'(req_rdy), 64'(3'b100));
    cyc();
    req_vld = 3'b000;
    mid();
    chk("rs_fresh_src", 64'(tag_req_src), 2);
    chk("rs_fresh_addr", 64'(tag_req_pld.addr), 64'h700);
    cyc();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("rs_idle%0d", k), 64'(tag_req_vld), 0);
      cyc();
    end

    chk("sb_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
